// File: rtl/dsp_mem_capture_ctrl.sv
// Capture sequencer for the circular sample memory: pre-trigger fill,
// trigger detection and post-trigger fill, one ADC row per memory clock.
module dsp_mem_capture_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_SAMPLES = 64,
    parameter int ADC_WIDTH   = 6
) (
    input  logic                                  i_clk_dig_mem,
    input  logic                                  i_reset,
    input  logic [NUM_SAMPLES-1:0][ADC_WIDTH-1:0] i_dat_mem,
    input  logic                                  i_arm,
    input  logic                                  i_abort,
    input  logic [1:0]                            i_trig_mode,
    input  logic                                  i_trig_ext,
    input  logic [ADC_WIDTH-1:0]                  i_trig_thresh,
    input  logic [ADDR_WIDTH-1:0]                 i_pre_depth,
    output logic                                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0]                 o_mem_waddr,
    output logic [ADDR_WIDTH-1:0]                 o_trig_addr,
    output logic [ADDR_WIDTH-1:0]                 o_start_addr,
    output logic                                  o_done,
    output logic [2:0]                            o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic                  arm_q;
    logic                  arm_edge;
    logic                  thresh_hit;
    logic                  trig_hit;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH-1:0] post_load;

    assign arm_edge  = i_arm & ~arm_q;
    assign post_load = {ADDR_WIDTH{1'b1}} - i_pre_depth;
    assign o_state   = state;

    always_comb begin
        thresh_hit = 1'b0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            if (i_dat_mem[i] >= i_trig_thresh) thresh_hit = 1'b1;
        end
    end

    always_comb begin
        trig_hit = 1'b0;
        unique case (i_trig_mode)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = thresh_hit;
            2'd2:    trig_hit = i_trig_ext;
            default: trig_hit = 1'b0;
        endcase
    end

    // o_mem_wen/o_mem_waddr describe the row being written in the current cycle
    always_ff @(posedge i_clk_dig_mem) begin
        if (i_reset) begin
            state        <= IDLE;
            arm_q        <= 1'b0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            o_mem_wen    <= 1'b0;
            o_mem_waddr  <= '0;
            o_trig_addr  <= '0;
            o_start_addr <= '0;
            o_done       <= 1'b0;
        end else begin
            arm_q <= i_arm;
            if (i_abort) begin
                state     <= IDLE;
                o_mem_wen <= 1'b0;
                o_done    <= 1'b0;
            end else if (arm_edge && (state == IDLE || state == DONE)) begin
                state       <= (i_pre_depth == '0) ? ARMED : PRE;
                pre_cnt     <= '0;
                o_mem_wen   <= 1'b1;
                o_mem_waddr <= '0;
                o_done      <= 1'b0;
            end else begin
                unique case (state)
                    PRE: begin
                        o_mem_waddr <= o_mem_waddr + 1'b1;
                        if (pre_cnt + 1'b1 == i_pre_depth) state <= ARMED;
                        else pre_cnt <= pre_cnt + 1'b1;
                    end
                    ARMED: begin
                        if (trig_hit) begin
                            o_trig_addr  <= o_mem_waddr;
                            o_start_addr <= o_mem_waddr - i_pre_depth;
                            post_cnt     <= post_load;
                            if (post_load == '0) begin
                                state     <= DONE;
                                o_mem_wen <= 1'b0;
                                o_done    <= 1'b1;
                            end else begin
                                state       <= POST;
                                o_mem_waddr <= o_mem_waddr + 1'b1;
                            end
                        end else begin
                            o_mem_waddr <= o_mem_waddr + 1'b1;
                        end
                    end
                    POST: begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == 1) begin
                            state     <= DONE;
                            o_mem_wen <= 1'b0;
                            o_done    <= 1'b1;
                        end else begin
                            o_mem_waddr <= o_mem_waddr + 1'b1;
                        end
                    end
                    default: o_mem_wen <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp_mem_capture_ctrl.sv
// Randomized bench for dsp_mem_capture_ctrl against a row-index reference
// model of the capture window (DEPTH = 16).
module tb_dsp_mem_capture_ctrl;

    localparam int AW = 4;
    localparam int NS = 64;
    localparam int AD = 6;
    localparam int D  = 2 ** AW;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NS-1:0][AD-1:0]  dat;
    logic                   arm;
    logic                   abort;
    logic [1:0]             mode;
    logic                   ext;
    logic [AD-1:0]          thr;
    logic [AW-1:0]          pre;
    logic                   wen;
    logic [AW-1:0]          waddr;
    logic [AW-1:0]          trig_addr;
    logic [AW-1:0]          start_addr;
    logic                   done;
    logic [2:0]             state;

    dsp_mem_capture_ctrl #(
        .ADDR_WIDTH (AW),
        .NUM_SAMPLES(NS),
        .ADC_WIDTH  (AD)
    ) dut (
        .i_clk_dig_mem(clk),
        .i_reset      (rst),
        .i_dat_mem    (dat),
        .i_arm        (arm),
        .i_abort      (abort),
        .i_trig_mode  (mode),
        .i_trig_ext   (ext),
        .i_trig_thresh(thr),
        .i_pre_depth  (pre),
        .o_mem_wen    (wen),
        .o_mem_waddr  (waddr),
        .o_trig_addr  (trig_addr),
        .o_start_addr (start_addr),
        .o_done       (done),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a capture is a sequence of row indices k = 0,1,2...
    // written to address k mod D; trigger index t is the first k >= pre
    // that hits; the last row is t + D-1-pre.
    bit m_act;
    bit m_arm_q;
    int m_k;
    int m_t;
    int m_wen;
    int m_waddr;
    int m_trig;
    int m_start;
    int m_done;
    int m_state;

    function automatic bit row_hit();
        bit h;
        h = 1'b0;
        case (mode)
            2'd0: h = 1'b1;
            2'd1: for (int i = 0; i < NS; i++) if (int'(dat[i]) >= int'(thr)) h = 1'b1;
            2'd2: h = ext;
            default: h = 1'b0;
        endcase
        return h;
    endfunction

    task automatic model_step();
        bit edge_seen;
        if (rst) begin
            m_act = 0; m_arm_q = 0; m_wen = 0; m_waddr = 0;
            m_trig = 0; m_start = 0; m_done = 0; m_state = 0;
            return;
        end
        edge_seen = arm && !m_arm_q;
        m_arm_q = arm;
        if (abort) begin
            m_act = 0; m_wen = 0; m_done = 0; m_state = 0;
        end else if (edge_seen && !m_act) begin
            m_act = 1; m_k = 0; m_t = -1;
            m_wen = 1; m_waddr = 0; m_done = 0;
            m_state = (pre == 0) ? 2 : 1;
        end else if (m_act) begin
            if (m_t < 0 && m_k >= int'(pre) && row_hit()) begin
                m_t = m_k;
                m_trig = m_k % D;
                m_start = (m_k - int'(pre)) % D;
            end
            if (m_t >= 0 && m_k == m_t + D - 1 - int'(pre)) begin
                m_act = 0; m_wen = 0; m_done = 1; m_state = 4;
            end else begin
                m_k++;
                m_waddr = m_k % D;
                m_state = (m_k < int'(pre)) ? 1 : (m_t < 0) ? 2 : 3;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("wen", wen, m_wen);
        if (m_wen != 0) chk("waddr", waddr, m_waddr);
        chk("trig_addr", trig_addr, m_trig);
        chk("start_addr", start_addr, m_start);
        chk("done", done, m_done);
        chk("state", state, m_state);
    endtask

    task automatic fill_row(input bit hit);
        int idx;
        for (int i = 0; i < NS; i++)
            dat[i] = (thr == 0) ? '0 : AD'($urandom_range(int'(thr) - 1, 0));
        if (hit) begin
            idx = $urandom_range(NS - 1, 0);
            dat[idx] = AD'($urandom_range(63, int'(thr)));
        end
    endtask

    initial begin
        int guard;
        rst = 1; arm = 0; abort = 0; mode = 0; ext = 0; thr = 6'd50; pre = 4;
        dat = '0;
        step();
        step();
        rst = 0;

        // mode 0, pre=4: 16 writes then done
        arm = 1;
        step();
        chk("first_addr", waddr, 0);
        for (int c = 2; c <= 17; c++) step();
        chk("p2_done", done, 1);
        chk("p2_trig", trig_addr, 4);
        chk("p2_start", start_addr, 0);

        // mode 2, pre=15, external pulse at addr 7 after fill
        arm = 0; mode = 2; pre = 15;
        step();
        arm = 1;
        step();
        guard = 0;
        while (!(m_state == 2 && m_waddr == 7) && guard < 100) begin
            step();
            guard++;
        end
        chk("p4_reach", guard < 100, 1);
        ext = 1;
        step();
        ext = 0;
        chk("p4_done", done, 1);
        chk("p4_trig", trig_addr, 7);
        chk("p4_start", start_addr, 8);

        // mode 3 never triggers; re-arm ignored, then abort
        arm = 0; mode = 3; pre = 2;
        step();
        arm = 1;
        for (int c = 0; c < 30; c++) begin
            arm = (c % 5 == 0);
            step();
        end
        chk("m3_armed", state, 2);
        abort = 1;
        step();
        abort = 0;
        chk("abort_idle", state, 0);
        chk("abort_trig_kept", trig_addr, 7);

        // randomized captures
        for (int n = 0; n < 4000; n++) begin
            if (!m_act && $urandom_range(3, 0) == 0) begin
                mode = 2'($urandom_range(3, 0));
                if ($urandom_range(7, 0) == 0) mode = 2'd3;
                else if (mode == 2'd3) mode = 2'd1;
                pre = AW'($urandom_range(D - 1, 0));
                thr = AD'($urandom_range(63, 0));
            end
            if ($urandom_range(7, 0) == 0) arm = ~arm;
            abort = ($urandom_range(199, 0) == 0);
            rst = ($urandom_range(499, 0) == 0);
            ext = ($urandom_range(19, 0) == 0);
            fill_row($urandom_range(24, 0) == 0);
            step();
        end
        rst = 1; abort = 0;
        step();
        rst = 0;
        chk("final_reset_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
